vend_controller: RTL
====================

# vend_controller

- Vending-machine sequencer downstream of the coin detector.
- Accumulates credit from the detector's `coin_value` output, prices and validates a product selection, and hands the item to the dispenser with a valid/ready handshake.
- Returns any remaining credit as change, one coin per handshake.
- Sole owner of the credit register; panel and dispenser logic talk only to this block.

## Interface
Parameters:
- `MAX_CREDIT`, default 99: highest credit the block holds; a coin that would exceed it is rejected.
- `TIMEOUT_CYC`, default 1_000_000: idle cycles in COLLECT before credit is refunded automatically.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `coin_value`  in  8  denomination from the coin detector (0, 1, 2, 5, 10); held non-zero while a coin is present.
- `sel_valid`  in  1  one-cycle selection strobe from the panel.
- `sel_item`  in  2  product index, sampled with `sel_valid`.
- `cancel`  in  1  one-cycle refund request.
- `dispense_valid`  out  1  item request to the dispenser.
- `dispense_item`  out  2  item index; stable while `dispense_valid`=1.
- `dispense_ready`  in  1  dispenser accepts the item.
- `change_valid`  out  1  a change coin is offered.
- `change_coin`  out  8  change denomination; stable while `change_valid`=1.
- `change_ready`  in  1  coin hopper accepts the offered coin.
- `credit`  out  8  current credit, for display.
- `coin_reject`  out  1  one-cycle pulse when a coin is refused.
- `sel_fail`  out  1  one-cycle pulse when a selection is refused.
- `busy`  out  1  high in DISPENSE and CHANGE.

## Operation
- States:
  - IDLE: credit 0.
  - COLLECT: credit > 0, waiting for a selection.
  - DISPENSE: handing an item to the dispenser.
  - CHANGE: paying out remaining credit.
- Coin event: `coin_value`≠0 while the registered previous `coin_value`=0. Exactly one event per coin however long it is held.
- Coin event in IDLE/COLLECT:
  - credit+value ≤ `MAX_CREDIT`: credit += value; IDLE→COLLECT.
  - Otherwise: pulse `coin_reject`; credit unchanged.
- Coin event in DISPENSE/CHANGE: always pulse `coin_reject`.
- `sel_valid` in COLLECT:
  - Credit (value before this cycle's coin) ≥ `PRICE[sel_item]`: credit -= price, latch item, →DISPENSE.
  - Otherwise: pulse `sel_fail` and stay in COLLECT.
- `sel_valid` in any other state: pulse `sel_fail`.
- Coin and a successful selection in the same cycle: credit_next = credit − price + value (overflow check on credit+value). The coin is not rejected.
- `cancel` in COLLECT →CHANGE. A successful `sel_valid` in the same cycle wins and `cancel` is dropped. `cancel` is ignored elsewhere.
- DISPENSE: `dispense_valid`=1. On `dispense_ready`: credit=0 →IDLE, else →CHANGE.
- CHANGE:
  - `change_coin` = largest of {10, 5, 2, 1} ≤ credit; `change_valid`=1.
  - On `change_ready`: credit -= `change_coin`; credit reaching 0 →IDLE.
- Timeout: counter runs only in COLLECT. It clears on any coin event, `sel_valid` or state entry. Reaching `TIMEOUT_CYC` forces →CHANGE, same as `cancel`.
- Credit never underflows and never exceeds `MAX_CREDIT`.

## Timing
- `rst_n` low asynchronously forces:
  - state IDLE, credit 0, timeout counter 0, previous-coin register 0;
  - all outputs 0.
- Reset mid-dispense or mid-change abandons the transaction; credit is lost.
- All outputs are registered. A coin event at edge N is reflected in `credit` after edge N+1. `coin_reject`/`sel_fail` are high for exactly the cycle after the event.
- `dispense_valid`/`change_valid` rise one cycle after the state transition. They hold, with stable data, until ready is sampled high. Ready with valid low is ignored.
- Back-to-back change coins: one per cycle while `change_ready` stays high. `change_coin` updates in the same cycle credit updates.

## Structure
- `vend_pkg` holds:
  - state enum;
  - `PRICE[0:3]` = {3, 5, 8, 12};
  - coin denomination constants {1, 2, 5, 10};
  - credit width (8).
- Greedy change selection is a pure function in `vend_pkg`.
- One sub-module, `vend_timeout`: loadable idle counter with `clear`, `enable` and `expired` ports.

## Test plan
- Insert 5 then 10 (each held 3 cycles) → credit 5 then 15; no `coin_reject`.
- Credit 15, select item 3 (price 12) → DISPENSE with `dispense_item`=3. Ready after 4 cycles → CHANGE offers 2, then 1 → IDLE with credit 0.
- Credit 95, insert 10 → `coin_reject` pulse, credit stays 95; then `cancel` → change 10×9, 5, → IDLE.
- Credit 4, select item 1 (price 5) → `sel_fail`, stays COLLECT. Same-cycle insert 1 + select item 1 at credit 4 → `sel_fail`, credit 5.
- Credit 7, no activity for `TIMEOUT_CYC` (bench overrides to 16) → CHANGE: 5, 2 → IDLE.
- Assert `rst_n` in CHANGE with `change_valid`=1 → all outputs 0 immediately; after release, IDLE and credit 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding,
// price table, coin denominations and greedy change selection.
package vend_pkg;

  localparam int CREDIT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_CHANGE
  } vend_state_e;

  // Index 0 in the lowest byte: PRICE[0]=3 .. PRICE[3]=12
  localparam logic [3:0][CREDIT_W-1:0] PRICE = {8'd12, 8'd8, 8'd5, 8'd3};

  localparam logic [CREDIT_W-1:0] COIN_1  = 8'd1;
  localparam logic [CREDIT_W-1:0] COIN_2  = 8'd2;
  localparam logic [CREDIT_W-1:0] COIN_5  = 8'd5;
  localparam logic [CREDIT_W-1:0] COIN_10 = 8'd10;

  function automatic logic [CREDIT_W-1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= COIN_10)     return COIN_10;
    else if (amt >= COIN_5) return COIN_5;
    else if (amt >= COIN_2) return COIN_2;
    else if (amt >= COIN_1) return COIN_1;
    else                    return '0;
  endfunction

endpackage

// File: rtl/vend_timeout.sv
// Idle counter: counts enabled cycles, restarts on clear or when disabled,
// and flags the cycle that completes TIMEOUT_CYC idle cycles.
module vend_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (clear || !enable || expired) cnt <= '0;
    else                                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, validates selections, hands
// items to the dispenser and pays change one coin per handshake.
module vend_controller
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT  = 99,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  input  logic                dispense_ready,
  output logic                change_valid,
  output logic [7:0]          change_coin,
  input  logic                change_ready,
  output logic [7:0]          credit,
  output logic                coin_reject,
  output logic                sel_fail,
  output logic                busy
);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  vend_state_e         state, state_next;
  logic [CREDIT_W-1:0] prev_coin, credit_next, price;
  logic [CREDIT_W:0]   sum;
  logic [1:0]          item_next;
  logic                coin_evt, coin_fits, reject, fail, expired;

  assign coin_evt  = (coin_value != '0) && (prev_coin == '0);
  assign sum       = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits = (sum <= MAX_C);
  assign price     = PRICE[sel_item];

  vend_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (coin_evt || sel_valid),
    .enable  (state == ST_COLLECT),
    .expired (expired)
  );

  always_comb begin
    state_next  = state;
    credit_next = credit;
    item_next   = dispense_item;
    reject      = 1'b0;
    fail        = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (coin_evt) begin
          if (coin_fits) begin
            credit_next = sum[CREDIT_W-1:0];
            if (state == ST_IDLE) state_next = ST_COLLECT;
          end else begin
            reject = 1'b1;
          end
        end
        // Affordability uses pre-coin credit; the coin is added on top.
        if (sel_valid) begin
          if (state == ST_COLLECT && credit >= price) begin
            credit_next = credit_next - price;
            item_next   = sel_item;
            state_next  = ST_DISPENSE;
          end else begin
            fail = 1'b1;
          end
        end else if (state == ST_COLLECT && (cancel || expired)) begin
          state_next = ST_CHANGE;
        end
      end
      ST_DISPENSE: begin
        reject = coin_evt;
        fail   = sel_valid;
        if (dispense_valid && dispense_ready)
          state_next = (credit == '0) ? ST_IDLE : ST_CHANGE;
      end
      ST_CHANGE: begin
        reject = coin_evt;
        fail   = sel_valid;
        if (change_valid && change_ready) begin
          credit_next = credit - change_coin;
          if (credit_next == '0) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      credit         <= '0;
      prev_coin      <= '0;
      dispense_valid <= 1'b0;
      dispense_item  <= '0;
      change_valid   <= 1'b0;
      change_coin    <= '0;
      coin_reject    <= 1'b0;
      sel_fail       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      credit         <= credit_next;
      prev_coin      <= coin_value;
      dispense_item  <= item_next;
      // Valids lag the state entry by one cycle and drop on the accepting edge.
      dispense_valid <= (state == ST_DISPENSE) && (state_next == ST_DISPENSE);
      change_valid   <= (state == ST_CHANGE) && (state_next == ST_CHANGE);
      change_coin    <= (state_next == ST_CHANGE) ? greedy_coin(credit_next) : '0;
      coin_reject    <= reject;
      sel_fail       <= fail;
      busy           <= (state_next == ST_DISPENSE) || (state_next == ST_CHANGE);
    end
  end

endmodule
